// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared types and constants for the snake body controller slice.
//   - dir_t   : movement direction encoding as driven on i_Dir
//   - state_t : controller state (waiting for item, running, game over)
//   - COORD_W : width of one x or y coordinate
//   - SIZE_W  : width of the body-size counter
//   - is_opposite() : true when two directions point in opposite ways
package snake_pkg;

  localparam int COORD_W = 6;
  localparam int SIZE_W  = 9;

  typedef enum logic [1:0] {
    UP    = 2'd0,  // y-1
    DOWN  = 2'd1,  // y+1
    LEFT  = 2'd2,  // x-1
    RIGHT = 2'd3   // x+1
  } dir_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return ((a == UP)   && (b == DOWN))  ||
           ((a == DOWN) && (b == UP))    ||
           ((a == LEFT) && (b == RIGHT)) ||
           ((a == RIGHT) && (b == LEFT));
  endfunction

endpackage

// File: rtl/snake_hit_check.sv
// snake_hit_check
//   Combinational position-versus-body compare.
//   Ports:
//     pos_x, pos_y   : position under test
//     body_x, body_y : packed segment coordinates, segment k at [COORD_W*k +: COORD_W]
//     count          : number of leading segments to compare against
//     hit            : 1 when the position equals any segment k < count
module snake_hit_check
  import snake_pkg::*;
#(
  parameter int MAX_SIZE = 100
) (
  input  logic [COORD_W-1:0]          pos_x,
  input  logic [COORD_W-1:0]          pos_y,
  input  logic [MAX_SIZE*COORD_W-1:0] body_x,
  input  logic [MAX_SIZE*COORD_W-1:0] body_y,
  input  logic [SIZE_W-1:0]           count,
  output logic                        hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < MAX_SIZE; k++) begin
      if ((k < 32'(count)) &&
          (body_x[k*COORD_W +: COORD_W] == pos_x) &&
          (body_y[k*COORD_W +: COORD_W] == pos_y)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
//   Owns the snake body and movement; consumer side of the item handshake.
//   On each tick in RUN the head advances one cell, walls and self-collision
//   are checked, and eating the item grows the body and re-requests an item.
//   Ports:
//     i_Clk, i_Rst           : clock, synchronous active-high reset
//     i_Tick                 : one-cycle movement strobe
//     i_Dir                  : commanded direction (0 up, 1 down, 2 left, 3 right)
//     i_Item_x/y, i_Item_valid : new item position and its done strobe
//     o_Item_req             : high while waiting for a new item
//     o_Body_x/y             : packed segment coordinates, segment 0 is the head
//     o_Body_size            : number of valid segments
//     o_Ate                  : one-cycle pulse when the item is eaten
//     o_Game_over            : sticky until reset
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int XSIZE     = 48,
  parameter int YSIZE     = 64,
  parameter int MAX_SIZE  = 100,
  parameter int INIT_SIZE = 3
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Tick,
  input  logic [1:0]                  i_Dir,
  input  logic [COORD_W-1:0]          i_Item_x,
  input  logic [COORD_W-1:0]          i_Item_y,
  input  logic                        i_Item_valid,
  output logic                        o_Item_req,
  output logic [MAX_SIZE*COORD_W-1:0] o_Body_x,
  output logic [MAX_SIZE*COORD_W-1:0] o_Body_y,
  output logic [SIZE_W-1:0]           o_Body_size,
  output logic                        o_Ate,
  output logic                        o_Game_over
);

  localparam logic [COORD_W:0]  STEP     = 1;
  localparam logic [SIZE_W-1:0] SIZE_ONE = 1;

  // Horizontal line of INIT_SIZE segments centred in the field, head rightmost.
  function automatic logic [MAX_SIZE*COORD_W-1:0] init_body(input logic is_x);
    logic [MAX_SIZE*COORD_W-1:0] b;
    b = '0;
    for (int unsigned k = 0; k < INIT_SIZE; k++) begin
      b[k*COORD_W +: COORD_W] = is_x ? COORD_W'(XSIZE/2 - int'(k))
                                     : COORD_W'(YSIZE/2);
    end
    return b;
  endfunction

  localparam logic [MAX_SIZE*COORD_W-1:0] INIT_X = init_body(1'b1);
  localparam logic [MAX_SIZE*COORD_W-1:0] INIT_Y = init_body(1'b0);

  state_t               state;
  dir_t                 cur_dir;
  logic [COORD_W-1:0]   item_x;
  logic [COORD_W-1:0]   item_y;

  dir_t                 cmd_dir;
  dir_t                 new_dir;
  logic [COORD_W:0]     nx;
  logic [COORD_W:0]     ny;
  logic                 wall;
  logic                 eat;
  logic                 self_hit;
  logic [SIZE_W-1:0]    cmp_cnt;
  logic [SIZE_W-1:0]    move_cnt;
  logic [SIZE_W-1:0]    size_next;
  logic [MAX_SIZE*COORD_W-1:0] shift_x;
  logic [MAX_SIZE*COORD_W-1:0] shift_y;

  always_comb begin
    cmd_dir = dir_t'(i_Dir);
    new_dir = is_opposite(cmd_dir, cur_dir) ? cur_dir : cmd_dir;

    // One extra bit so a step below 0 lands at all-ones and fails the bound test.
    nx = {1'b0, o_Body_x[COORD_W-1:0]};
    ny = {1'b0, o_Body_y[COORD_W-1:0]};
    case (new_dir)
      UP:      ny = ny - STEP;
      DOWN:    ny = ny + STEP;
      LEFT:    nx = nx - STEP;
      default: nx = nx + STEP;
    endcase

    wall = (nx >= (COORD_W+1)'(XSIZE)) || (ny >= (COORD_W+1)'(YSIZE));
    eat  = (nx == {1'b0, item_x}) && (ny == {1'b0, item_y});

    // The tail only vacates its cell when the snake does not grow.
    cmp_cnt = eat ? o_Body_size : (o_Body_size - SIZE_ONE);

    // Slots at or beyond the live length hold still; on eat one extra slot
    // receives the old tail (silently absent when already at MAX_SIZE).
    move_cnt = eat ? (o_Body_size + SIZE_ONE) : o_Body_size;
    shift_x  = o_Body_x;
    shift_y  = o_Body_y;
    shift_x[COORD_W-1:0] = nx[COORD_W-1:0];
    shift_y[COORD_W-1:0] = ny[COORD_W-1:0];
    for (int unsigned k = 1; k < MAX_SIZE; k++) begin
      if (k < 32'(move_cnt)) begin
        shift_x[k*COORD_W +: COORD_W] = o_Body_x[(k-1)*COORD_W +: COORD_W];
        shift_y[k*COORD_W +: COORD_W] = o_Body_y[(k-1)*COORD_W +: COORD_W];
      end
    end

    size_next = (eat && (o_Body_size < SIZE_W'(MAX_SIZE))) ? (o_Body_size + SIZE_ONE)
                                                           : o_Body_size;
  end

  snake_hit_check #(
    .MAX_SIZE (MAX_SIZE)
  ) u_self_hit (
    .pos_x  (nx[COORD_W-1:0]),
    .pos_y  (ny[COORD_W-1:0]),
    .body_x (o_Body_x),
    .body_y (o_Body_y),
    .count  (cmp_cnt),
    .hit    (self_hit)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= REQ;
      cur_dir     <= RIGHT;
      item_x      <= '0;
      item_y      <= '0;
      o_Body_x    <= INIT_X;
      o_Body_y    <= INIT_Y;
      o_Body_size <= SIZE_W'(INIT_SIZE);
      o_Item_req  <= 1'b0;
      o_Ate       <= 1'b0;
      o_Game_over <= 1'b0;
    end else begin
      o_Ate <= 1'b0;
      case (state)
        REQ: begin
          o_Item_req <= 1'b1;
          if (i_Item_valid) begin
            item_x     <= i_Item_x;
            item_y     <= i_Item_y;
            o_Item_req <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (i_Tick) begin
            if (wall || self_hit) begin
              o_Game_over <= 1'b1;
              state       <= OVER;
            end else begin
              cur_dir     <= new_dir;
              o_Body_x    <= shift_x;
              o_Body_y    <= shift_y;
              o_Body_size <= size_next;
              if (eat) begin
                o_Ate      <= 1'b1;
                o_Item_req <= 1'b1;
                state      <= REQ;
              end
            end
          end
        end
        OVER: begin
          o_Game_over <= 1'b1;
        end
        default: begin
          state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: the driver updates a queue-based
// snake model and pushes the expected outputs; a monitor pops one entry per
// accepted tick/valid cycle and compares.
module tb_snake_body_ctrl;

  localparam int MAXS = 100;
  localparam int W    = MAXS * 6;

  logic         clk = 1'b0;
  logic         i_Rst = 1'b1;
  logic         i_Tick = 1'b0;
  logic [1:0]   i_Dir = 2'd3;
  logic [5:0]   i_Item_x = '0;
  logic [5:0]   i_Item_y = '0;
  logic         i_Item_valid = 1'b0;
  logic         o_Item_req;
  logic [W-1:0] o_Body_x;
  logic [W-1:0] o_Body_y;
  logic [8:0]   o_Body_size;
  logic         o_Ate;
  logic         o_Game_over;

  always #5 clk = ~clk;

  snake_body_ctrl #(
    .XSIZE     (48),
    .YSIZE     (64),
    .MAX_SIZE  (MAXS),
    .INIT_SIZE (3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Tick       (i_Tick),
    .i_Dir        (i_Dir),
    .i_Item_x     (i_Item_x),
    .i_Item_y     (i_Item_y),
    .i_Item_valid (i_Item_valid),
    .o_Item_req   (o_Item_req),
    .o_Body_x     (o_Body_x),
    .o_Body_y     (o_Body_y),
    .o_Body_size  (o_Body_size),
    .o_Ate        (o_Ate),
    .o_Game_over  (o_Game_over)
  );

  typedef struct {
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [W-1:0] mask;
    int           size;
    bit           ate;
    bit           go;
    bit           req;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference snake: queues of cells, index 0 is the head.
  int bx[$];
  int by[$];
  int mdir;    // 0 up, 1 down, 2 left, 3 right
  int mstate;  // 0 waiting for item, 1 running, 2 over
  int itx, ity;

  function automatic void delta(input int d, output int dx, output int dy);
    dx = 0; dy = 0;
    case (d)
      0: dy = -1;
      1: dy = 1;
      2: dx = -1;
      default: dx = 1;
    endcase
  endfunction

  function automatic int eff_dir(input int d);
    if ((d == 0 && mdir == 1) || (d == 1 && mdir == 0) ||
        (d == 2 && mdir == 3) || (d == 3 && mdir == 2)) return mdir;
    return d;
  endfunction

  function automatic void model_reset();
    bx = '{24, 23, 22};
    by = '{32, 32, 32};
    mdir = 3; mstate = 0; itx = 0; ity = 0;
  endfunction

  function automatic exp_t model_apply(input bit tick, input int dir, input bit valid,
                                       input int x, input int y);
    exp_t e;
    bit ate, wall, eat, hit;
    int d, dx, dy, nx, ny, lim;
    ate = 0;
    if (mstate == 0 && valid) begin
      itx = x; ity = y; mstate = 1;
    end else if (mstate == 1 && tick) begin
      d = eff_dir(dir);
      delta(d, dx, dy);
      nx = bx[0] + dx;
      ny = by[0] + dy;
      wall = (nx < 0) || (nx >= 48) || (ny < 0) || (ny >= 64);
      eat = (nx == itx) && (ny == ity);
      lim = eat ? bx.size() : bx.size() - 1;
      hit = 0;
      for (int k = 0; k < lim; k++) if (bx[k] == nx && by[k] == ny) hit = 1;
      if (wall || hit) begin
        mstate = 2;
      end else begin
        bx.push_front(nx);
        by.push_front(ny);
        if (!eat || bx.size() > MAXS) begin
          void'(bx.pop_back());
          void'(by.pop_back());
        end
        mdir = d;
        if (eat) begin ate = 1; mstate = 0; end
      end
    end
    e.ex = '0; e.ey = '0; e.mask = '0;
    for (int k = 0; k < bx.size(); k++) begin
      e.ex[k*6 +: 6]   = 6'(bx[k]);
      e.ey[k*6 +: 6]   = 6'(by[k]);
      e.mask[k*6 +: 6] = 6'h3F;
    end
    e.size = bx.size();
    e.ate  = ate;
    e.go   = (mstate == 2);
    e.req  = (mstate == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  bit   ev = 1'b0;
  exp_t me;

  always @(posedge clk) ev <= !i_Rst && (i_Tick || i_Item_valid);

  always @(negedge clk) begin
    if (ev) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        me = sbq.pop_front();
        checks++;
        if ((o_Body_x & me.mask) !== me.ex) begin
          errors++;
          $display("FAIL body_x actual=%h expected=%h", o_Body_x & me.mask, me.ex);
        end
        checks++;
        if ((o_Body_y & me.mask) !== me.ey) begin
          errors++;
          $display("FAIL body_y actual=%h expected=%h", o_Body_y & me.mask, me.ey);
        end
        chk("size", int'(o_Body_size), me.size);
        chk("ate", int'(o_Ate), int'(me.ate));
        chk("game_over", int'(o_Game_over), int'(me.go));
        chk("item_req", int'(o_Item_req), int'(me.req));
      end
    end else begin
      chk("ate_quiet", int'(o_Ate), 0);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit tick, input int dir, input bit valid, input int x, input int y);
    @(negedge clk);
    i_Tick = tick; i_Dir = 2'(dir); i_Item_valid = valid;
    i_Item_x = 6'(x); i_Item_y = 6'(y);
    if (tick || valid) sbq.push_back(model_apply(tick, dir, valid, x, y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    logic [W-1:0] ix, iy;
    @(negedge clk);
    i_Rst = 1'b1; i_Tick = 1'b0; i_Item_valid = 1'b0;
    @(negedge clk);
    ix = '0; iy = '0;
    for (int k = 0; k < 3; k++) begin
      ix[k*6 +: 6] = 6'(24 - k);
      iy[k*6 +: 6] = 6'(32);
    end
    checks++;
    if (o_Body_x !== ix || o_Body_y !== iy) begin
      errors++;
      $display("FAIL reset_body actual=%h/%h expected=%h/%h",
               o_Body_x[59:0], o_Body_y[59:0], ix[59:0], iy[59:0]);
    end
    chk("reset_size", int'(o_Body_size), 3);
    chk("reset_req", int'(o_Item_req), 0);
    chk("reset_ate", int'(o_Ate), 0);
    chk("reset_go", int'(o_Game_over), 0);
    model_reset();
    i_Rst = 1'b0;
    @(negedge clk);
    chk("req_after_release", int'(o_Item_req), 1);
  endtask

  // Place the item on the cell ahead and take the eating tick.
  task automatic feed(input int d);
    int dx, dy;
    delta(eff_dir(d), dx, dy);
    cyc(0, 0, 1, bx[0] + dx, by[0] + dy);
    cyc(1, d, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r, dx, dy, x, y;
    model_reset();

    // Reset and first item.
    do_reset();
    cyc(0, 0, 1, 30, 10);
    idle(1);

    // Eat and grow, then reversal rejected.
    do_reset();
    cyc(0, 0, 1, 25, 32);
    cyc(1, 3, 0, 0, 0);
    idle(1);
    chk("eat_head_x", int'(o_Body_x[5:0]), 25);
    chk("eat_size", int'(o_Body_size), 4);
    chk("eat_seg3_x", int'(o_Body_x[23:18]), 22);
    cyc(0, 0, 1, 40, 40);
    cyc(1, 2, 0, 0, 0);
    idle(1);
    chk("reverse_head_x", int'(o_Body_x[5:0]), 26);

    // Tail vacate: 2x2 loop, head steps into the current tail.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    idle(1);
    chk("vacate_no_over", int'(o_Game_over), 0);

    // Paused in REQ, and tick coincident with valid is dropped.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    cyc(1, 3, 1, 40, 40);
    cyc(1, 3, 0, 0, 0);
    idle(1);

    // In-flight ate cancelled by reset.
    do_reset();
    cyc(0, 0, 1, 25, 32);
    cyc(1, 3, 0, 0, 0);
    do_reset();

    // Self-collision.
    feed(3);
    feed(3);
    cyc(0, 0, 1, 40, 40);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    idle(1);
    chk("self_hit_over", int'(o_Game_over), 1);
    cyc(0, 0, 1, 5, 5);

    // Wall at y=0.
    do_reset();
    cyc(0, 0, 1, 30, 10);
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0);
    idle(1);
    chk("wall_head_y", int'(o_Body_y[5:0]), 0);
    chk("wall_not_yet", int'(o_Game_over), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    idle(1);
    chk("wall_head_y_frozen", int'(o_Body_y[5:0]), 0);
    chk("wall_over", int'(o_Game_over), 1);

    // Growth to saturation along a serpentine path.
    do_reset();
    for (int i = 0; i < 110; i++) begin
      d = mdir;
      if (mdir == 3 && bx[0] >= 46) d = 1;
      else if (mdir == 2 && bx[0] <= 1) d = 1;
      else if (mdir == 1) d = (bx[0] >= 46) ? 2 : 3;
      feed(d);
    end
    idle(1);
    chk("saturated_size", int'(o_Body_size), MAXS);

    // Randomised play.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 7));
      if (mstate == 2) begin
        if (r < 2) do_reset();
        else cyc(r[0], int'($urandom_range(0, 3)), r[1], 1, 1);
      end else if (mstate == 0) begin
        if (r == 0) begin
          cyc(1, int'($urandom_range(0, 3)), 0, 0, 0);
        end else begin
          x = int'($urandom_range(0, 47));
          y = int'($urandom_range(0, 63));
          if (r > 3) begin
            delta(mdir, dx, dy);
            if (bx[0] + dx >= 0 && bx[0] + dx < 48 && by[0] + dy >= 0 && by[0] + dy < 64) begin
              x = bx[0] + dx;
              y = by[0] + dy;
            end
          end
          cyc(r == 7, int'($urandom_range(0, 3)), 1, x, y);
        end
      end else begin
        if (r < 5) cyc(1, int'($urandom_range(0, 3)), r == 0, 7, 7);
        else idle(1);
      end
    end
    idle(3);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
